// File: rtl/fetch_unit.sv
// Instruction fetch stage for the 6502 softcore: fetches opcode plus 0-2 operand bytes
// (size from the downstream decoder) and hands the assembled instruction to execute.
module fetch_unit #(
    parameter logic [15:0] RESET_PC = 16'h0200
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [15:0] mem_addr,
    output logic        mem_rd,
    input  logic        mem_gnt,
    input  logic [7:0]  mem_rdata,
    output logic [7:0]  dec_opcode,
    input  logic [1:0]  dec_size,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [7:0]  instr_opcode,
    output logic [7:0]  instr_op1,
    output logic [7:0]  instr_op2,
    output logic [15:0] instr_pc,
    output logic [15:0] instr_next_pc,
    input  logic        redirect,
    input  logic [15:0] redirect_pc
);

    localparam int unsigned AW = 16;
    localparam int unsigned DW = 8;

    typedef enum logic [2:0] {
        RST, REQ_OP, WAIT_OP, REQ_B1, WAIT_B1, REQ_B2, WAIT_B2, VALID
    } state_e;

    state_e          state_q, state_d;
    logic [AW-1:0]   pc_q, pc_d;
    logic [AW-1:0]   ipc_q, ipc_d;
    logic [AW-1:0]   npc_q, npc_d;
    logic [DW-1:0]   opc_q, opc_d;
    logic [DW-1:0]   op1_q, op1_d;
    logic [DW-1:0]   op2_q, op2_d;
    logic            sz3_q, sz3_d;

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RST;
            pc_q    <= RESET_PC;
            ipc_q   <= '0;
            npc_q   <= '0;
            opc_q   <= '0;
            op1_q   <= '0;
            op2_q   <= '0;
            sz3_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ipc_q   <= ipc_d;
            npc_q   <= npc_d;
            opc_q   <= opc_d;
            op1_q   <= op1_d;
            op2_q   <= op2_d;
            sz3_q   <= sz3_d;
        end
    end

    // Next-state and request generation
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ipc_d   = ipc_q;
        npc_d   = npc_q;
        opc_d   = opc_q;
        op1_d   = op1_q;
        op2_d   = op2_q;
        sz3_d   = sz3_q;
        mem_rd  = 1'b0;

        case (state_q)
            RST: state_d = REQ_OP;
            REQ_OP: begin
                mem_rd = 1'b1;
                if (mem_gnt) begin
                    ipc_d   = pc_q;
                    pc_d    = AW'(pc_q + 16'd1);
                    op1_d   = '0;
                    op2_d   = '0;
                    state_d = WAIT_OP;
                end
            end
            WAIT_OP: begin
                opc_d = mem_rdata;
                sz3_d = (dec_size == 2'd3);
                // Size 0 from the decoder is treated as a single-byte instruction
                if (dec_size[1]) begin
                    state_d = REQ_B1;
                end else begin
                    npc_d   = pc_q;
                    state_d = VALID;
                end
            end
            REQ_B1: begin
                mem_rd = 1'b1;
                if (mem_gnt) begin
                    pc_d    = AW'(pc_q + 16'd1);
                    state_d = WAIT_B1;
                end
            end
            WAIT_B1: begin
                op1_d = mem_rdata;
                if (sz3_q) begin
                    state_d = REQ_B2;
                end else begin
                    npc_d   = pc_q;
                    state_d = VALID;
                end
            end
            REQ_B2: begin
                mem_rd = 1'b1;
                if (mem_gnt) begin
                    pc_d    = AW'(pc_q + 16'd1);
                    state_d = WAIT_B2;
                end
            end
            WAIT_B2: begin
                op2_d   = mem_rdata;
                npc_d   = pc_q;
                state_d = VALID;
            end
            VALID: begin
                if (instr_ready) state_d = REQ_OP;
            end
        endcase

        // Redirect abandons whatever is in flight, including a same-cycle grant
        if (redirect && (state_q != RST)) begin
            state_d = REQ_OP;
            pc_d    = redirect_pc;
        end
    end

    assign mem_addr      = pc_q;
    assign dec_opcode    = (state_q == WAIT_OP) ? mem_rdata : opc_q;
    assign instr_valid   = (state_q == VALID);
    assign instr_opcode  = opc_q;
    assign instr_op1     = op1_q;
    assign instr_op2     = op2_q;
    assign instr_pc      = ipc_q;
    assign instr_next_pc = npc_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus randomized grant/ready/redirect traffic
// checked against an instruction-level model of the fetch stream.
module tb_fetch_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [15:0] mem_addr, redirect_pc, instr_pc, instr_next_pc;
    logic        mem_rd, mem_gnt, instr_valid, instr_ready, redirect;
    logic [7:0]  mem_rdata, dec_opcode, instr_opcode, instr_op1, instr_op2;
    logic [1:0]  dec_size;

    logic [15:0] w_mem_addr, w_redirect_pc, w_instr_pc, w_instr_next_pc;
    logic        w_mem_rd, w_mem_gnt, w_instr_valid, w_instr_ready, w_redirect;
    logic [7:0]  w_mem_rdata, w_dec_opcode, w_instr_opcode, w_instr_op1, w_instr_op2;
    logic [1:0]  w_dec_size;

    logic [7:0] mem [0:65535];

    fetch_unit u_dut (
        .clk(clk), .rst_n(rst_n), .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_gnt(mem_gnt),
        .mem_rdata(mem_rdata), .dec_opcode(dec_opcode), .dec_size(dec_size),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr_opcode(instr_opcode),
        .instr_op1(instr_op1), .instr_op2(instr_op2), .instr_pc(instr_pc),
        .instr_next_pc(instr_next_pc), .redirect(redirect), .redirect_pc(redirect_pc)
    );

    fetch_unit #(.RESET_PC(16'hFFFF)) u_wrap (
        .clk(clk), .rst_n(rst_n), .mem_addr(w_mem_addr), .mem_rd(w_mem_rd), .mem_gnt(w_mem_gnt),
        .mem_rdata(w_mem_rdata), .dec_opcode(w_dec_opcode), .dec_size(w_dec_size),
        .instr_valid(w_instr_valid), .instr_ready(w_instr_ready), .instr_opcode(w_instr_opcode),
        .instr_op1(w_instr_op1), .instr_op2(w_instr_op2), .instr_pc(w_instr_pc),
        .instr_next_pc(w_instr_next_pc), .redirect(w_redirect), .redirect_pc(w_redirect_pc)
    );

    // Decoder stand-in: a few named opcodes, otherwise the low two opcode bits
    function automatic logic [1:0] size_f(input logic [7:0] op);
        case (op)
            8'hEA:   return 2'd1;
            8'h4C:   return 2'd3;
            8'hA9:   return 2'd2;
            default: return op[1:0];
        endcase
    endfunction

    function automatic int eff_size(input logic [7:0] op);
        logic [1:0] s;
        s = size_f(op);
        return (s == 2'd0) ? 1 : int'(s);
    endfunction

    assign dec_size   = size_f(dec_opcode);
    assign w_dec_size = size_f(w_dec_opcode);

    int n_pass = 0;
    int n_fail = 0;
    int n_total = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Instruction-level model state
    logic [15:0] m_pc, m_paddr, last_addr, w_laddr, blk_addr;
    int          m_k, m_el, m_st, rdy_hold, blk_n;
    bit          m_vseen, m_pwait, last_gnt, w_last, rnd_mode;
    logic [15:0] gq[$];

    bit          w_seen;
    logic [7:0]  w_op, w_o1, w_o2;
    logic [15:0] w_ipc, w_npc;

    task automatic restart();
        m_k = 0; m_el = 0; m_st = 0; m_vseen = 1'b0;
    endtask

    task automatic model_step();
        logic [7:0]  op, e1, e2;
        logic [15:0] npc;
        int          s;
        op  = mem[m_pc];
        s   = eff_size(op);
        e1  = (s >= 2) ? mem[16'(m_pc + 16'd1)] : 8'h00;
        e2  = (s == 3) ? mem[16'(m_pc + 16'd2)] : 8'h00;
        npc = 16'(m_pc + 16'(s));
        if (m_pwait) begin
            chk("hold_rd", 32'(mem_rd), 32'd1);
            chk("hold_addr", 32'(mem_addr), 32'(m_paddr));
        end
        if (instr_valid) begin
            chk("v_opcode", 32'(instr_opcode), 32'(op));
            chk("v_dec_opcode", 32'(dec_opcode), 32'(op));
            chk("v_op1", 32'(instr_op1), 32'(e1));
            chk("v_op2", 32'(instr_op2), 32'(e2));
            chk("v_pc", 32'(instr_pc), 32'(m_pc));
            chk("v_next_pc", 32'(instr_next_pc), 32'(npc));
            chk("v_no_rd", 32'(mem_rd), 32'd0);
            if (!m_vseen) begin
                chk("latency", 32'(m_el), 32'(2 * s + m_st));
                m_vseen = 1'b1;
            end
        end
        if (mem_rd && mem_gnt) begin
            chk("req_addr", 32'(mem_addr), 32'(16'(m_pc + 16'(m_k))));
            chk("req_count", 32'(m_k < s), 32'd1);
            gq.push_back(mem_addr);
            m_k++;
        end
        if (mem_rd && !mem_gnt) m_st++;
        if (m_el == 201) chk("watchdog", 32'(m_el), 32'd200);
        m_pwait = mem_rd && !mem_gnt && !redirect;
        m_paddr = mem_addr;
        if (redirect) begin
            m_pc = redirect_pc;
            restart();
        end else if (instr_valid && instr_ready) begin
            m_pc = npc;
            restart();
        end else begin
            m_el++;
        end
    endtask

    task automatic drive(input bit redir, input logic [15:0] rpc);
        mem_rdata   = last_gnt ? mem[last_addr] : 8'($urandom);
        w_mem_rdata = w_last ? mem[w_laddr] : 8'($urandom);
        if (blk_n > 0 && mem_rd && mem_addr == blk_addr) begin
            mem_gnt = 1'b0;
            blk_n--;
        end else begin
            mem_gnt = rnd_mode ? ($urandom_range(0, 9) < 7) : 1'b1;
        end
        if (rdy_hold > 0) begin
            instr_ready = 1'b0;
            if (instr_valid) rdy_hold--;
        end else begin
            instr_ready = rnd_mode ? ($urandom_range(0, 9) < 6) : 1'b1;
        end
        redirect    = redir;
        redirect_pc = rpc;
        #1;
        if (w_instr_valid && !w_seen) begin
            w_seen = 1'b1;
            w_op = w_instr_opcode; w_o1 = w_instr_op1; w_o2 = w_instr_op2;
            w_ipc = w_instr_pc; w_npc = w_instr_next_pc;
        end
    endtask

    task automatic tick();
        model_step();
        last_gnt  = mem_rd && mem_gnt;
        last_addr = mem_addr;
        w_last    = w_mem_rd && w_mem_gnt;
        w_laddr   = w_mem_addr;
        @(posedge clk);
        #1;
    endtask

    // Asserts reset, checks reset values, releases it and consumes the RST cycle
    task automatic do_reset();
        rst_n = 1'b0; redirect = 1'b0; mem_gnt = 1'b0; instr_ready = 1'b0;
        #1;
        chk("rst_rd", 32'(mem_rd), 32'd0);
        chk("rst_addr", 32'(mem_addr), 32'h0200);
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_opcode", 32'(instr_opcode), 32'd0);
        chk("rst_ops", 32'({instr_op1, instr_op2}), 32'd0);
        chk("rst_pcs", 32'({instr_pc, instr_next_pc}), 32'd0);
        chk("rst_dec", 32'(dec_opcode), 32'd0);
        chk("rst_w_addr", 32'(w_mem_addr), 32'hFFFF);
        m_pc = 16'h0200; restart(); m_el = -1; m_pwait = 1'b0;
        last_gnt = 1'b0; w_last = 1'b0; gq.delete(); blk_n = 0; rdy_hold = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive(1'b0, 16'h0);
        chk("rst_cycle_rd", 32'(mem_rd), 32'd0);
        tick();
    endtask

    task automatic run_to_valid(output int c);
        c = 0;
        drive(1'b0, 16'h0);
        while (!instr_valid && c < 40) begin
            tick();
            c++;
            drive(1'b0, 16'h0);
        end
        if (!instr_valid) chk("valid_timeout", 32'(c), 32'd0);
    endtask

    initial begin
        int          c;
        bit          r;
        logic [15:0] t;
        rst_n = 1'b1; rnd_mode = 1'b0; w_seen = 1'b0;
        w_mem_gnt = 1'b1; w_instr_ready = 1'b1; w_redirect = 1'b0; w_redirect_pc = '0;
        mem_gnt = 1'b0; instr_ready = 1'b0; redirect = 1'b0; redirect_pc = '0;
        mem_rdata = '0; w_mem_rdata = '0; blk_n = 0; rdy_hold = 0; blk_addr = '0;
        for (int i = 0; i < 65536; i++) mem[i] = 8'hEA;
        mem[16'hFFFF] = 8'hA9; mem[16'h0000] = 8'h77;
        #2;

        // Single-byte NOP
        mem[16'h0200] = 8'hEA;
        do_reset();
        run_to_valid(c);
        chk("t1_lat", 32'(c), 32'd2);
        chk("t1_op", 32'(instr_opcode), 32'hEA);
        chk("t1_ops", 32'({instr_op1, instr_op2}), 32'h0);
        chk("t1_pc", 32'(instr_pc), 32'h0200);
        chk("t1_npc", 32'(instr_next_pc), 32'h0201);
        tick();

        // JMP abs, three bytes
        mem[16'h0200] = 8'h4C; mem[16'h0201] = 8'h34; mem[16'h0202] = 8'h12;
        do_reset();
        run_to_valid(c);
        chk("t2_lat", 32'(c), 32'd6);
        chk("t2_op1", 32'(instr_op1), 32'h34);
        chk("t2_op2", 32'(instr_op2), 32'h12);
        chk("t2_npc", 32'(instr_next_pc), 32'h0203);
        chk("t2_nreq", 32'(gq.size()), 32'd3);
        if (gq.size() == 3) begin
            chk("t2_req0", 32'(gq[0]), 32'h0200);
            chk("t2_req1", 32'(gq[1]), 32'h0201);
            chk("t2_req2", 32'(gq[2]), 32'h0202);
        end
        tick();

        // Wrapping instance: fetched opcode at FFFF, operand at 0000
        chk("w_seen", 32'(w_seen), 32'd1);
        chk("w_pc", 32'(w_ipc), 32'hFFFF);
        chk("w_op", 32'(w_op), 32'hA9);
        chk("w_op1", 32'(w_o1), 32'h77);
        chk("w_op2", 32'(w_o2), 32'h00);
        chk("w_npc", 32'(w_npc), 32'h0001);

        // Execute stall for five cycles
        mem[16'h0200] = 8'hA9; mem[16'h0201] = 8'h55; mem[16'h0202] = 8'hEA;
        do_reset();
        rdy_hold = 5;
        run_to_valid(c);
        chk("t3_lat", 32'(c), 32'd4);
        for (int i = 0; i < 5; i++) begin
            chk("t3_stall_valid", 32'(instr_valid), 32'd1);
            chk("t3_stall_rd", 32'(mem_rd), 32'd0);
            chk("t3_stall_op1", 32'(instr_op1), 32'h55);
            tick();
            drive(1'b0, 16'h0);
        end
        chk("t3_ready_valid", 32'(instr_valid), 32'd1);
        tick();
        drive(1'b0, 16'h0);
        chk("t3_next_rd", 32'(mem_rd), 32'd1);
        chk("t3_next_addr", 32'(mem_addr), 32'h0202);
        chk("t3_next_valid", 32'(instr_valid), 32'd0);
        tick();

        // Three grant-free cycles on the operand request
        do_reset();
        blk_addr = 16'h0201; blk_n = 3;
        run_to_valid(c);
        chk("t4_lat", 32'(c), 32'd7);
        chk("t4_op1", 32'(instr_op1), 32'h55);
        chk("t4_npc", 32'(instr_next_pc), 32'h0202);
        tick();

        // Redirect while the operand byte is returning
        mem[16'h0300] = 8'hEA;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 16'h0);
            chk("t5_pre_valid", 32'(instr_valid), 32'd0);
            tick();
        end
        drive(1'b1, 16'h0300);
        chk("t5_wait_b1_rd", 32'(mem_rd), 32'd0);
        tick();
        drive(1'b0, 16'h0);
        chk("t5_redir_rd", 32'(mem_rd), 32'd1);
        chk("t5_redir_addr", 32'(mem_addr), 32'h0300);
        chk("t5_redir_valid", 32'(instr_valid), 32'd0);
        run_to_valid(c);
        chk("t5_lat", 32'(c), 32'd2);
        chk("t5_op", 32'(instr_opcode), 32'hEA);
        chk("t5_pc", 32'(instr_pc), 32'h0300);
        tick();

        // Reset in the middle of an instruction
        do_reset();
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 16'h0);
            tick();
        end
        drive(1'b0, 16'h0);
        do_reset();
        run_to_valid(c);
        chk("t6_lat", 32'(c), 32'd4);
        chk("t6_op1", 32'(instr_op1), 32'h55);
        tick();

        // Random traffic over random memory
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        rnd_mode = 1'b1;
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            r = ($urandom_range(0, 24) == 0);
            case ($urandom_range(0, 3))
                0:       t = 16'hFFFE;
                1:       t = 16'hFFFF;
                default: t = 16'($urandom);
            endcase
            drive(r, t);
            tick();
            if (i % 1000 == 999) do_reset();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage of the 6502 softcore; sits directly upstream of the combinational decoder.
- Reads the opcode byte from memory and drives it to the decoder. Uses the decoder's returned instruction size (1/2/3) to fetch 0, 1 or 2 operand bytes.
- Presents the assembled instruction to execute over a valid/ready handshake.
- Accepts PC redirects from execute (JMP, taken branch).

Parameters:
- RESET_PC, 16'h0200, PC value loaded on reset.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- mem_addr  out  16  byte read address.
- mem_rd  out  1  read request; held with stable mem_addr until granted.
- mem_gnt  in  1  request accepted this cycle when mem_rd=1.
- mem_rdata  in  8  read data; valid exactly one cycle after the grant cycle.
- dec_opcode  out  8  opcode to decoder.
- dec_size  in  2  decoder instr_size for dec_opcode (combinational return).
- instr_valid  out  1  assembled instruction available.
- instr_ready  in  1  execute accepts the instruction.
- instr_opcode  out  8  opcode byte.
- instr_op1  out  8  first operand byte; 0 if absent.
- instr_op2  out  8  second operand byte (absolute high byte); 0 if absent.
- instr_pc  out  16  address of the opcode byte.
- instr_next_pc  out  16  address following the last instruction byte.
- redirect  in  1  one-cycle pulse: discard current fetch and restart at redirect_pc.
- redirect_pc  in  16  new fetch address.

Behaviour:
- States: RST, REQ_OP, WAIT_OP, REQ_B1, WAIT_B1, REQ_B2, WAIT_B2, VALID.
- Reset (async, rst_n=0):
  - state=RST, pc=RESET_PC.
  - All outputs 0 except mem_addr=RESET_PC.
  - RST→REQ_OP on the first clock after deassertion, so mem_rd stays 0 for that cycle.
- REQ_OP:
  - mem_rd=1, mem_addr=pc.
  - On mem_gnt: instr_pc<=pc, pc<=pc+1, go to WAIT_OP.
- WAIT_OP:
  - dec_opcode=mem_rdata (bypass); opcode register <= mem_rdata.
  - dec_size sampled this cycle: 1 or 0 (0 treated as 1) → VALID; 2 or 3 → REQ_B1.
  - Remember dec_size==3.
  - In all other states dec_opcode = opcode register.
- REQ_B1 / WAIT_B1:
  - Same request pattern at pc; pc increments on grant.
  - In WAIT_B1, op1<=mem_rdata, then go to REQ_B2 if size 3, else VALID.
- REQ_B2 / WAIT_B2:
  - Same pattern; op2<=mem_rdata, then go to VALID.
- Operand registers are cleared to 0 on entry to WAIT_OP, so unused operands read 0.
- VALID:
  - instr_valid=1; all instr_* outputs held stable while instr_ready=0.
  - instr_next_pc=pc.
  - On instr_ready go to REQ_OP; instr_valid=0 the next cycle. No prefetch overlap.
- Latency with zero-wait grants (cycle 0 = first REQ_OP cycle): instr_valid asserts at cycle 2 / 4 / 6 for 1 / 2 / 3-byte instructions.
- Each mem_gnt-free cycle in a REQ_* state adds one cycle.
- PC arithmetic is 16-bit modulo: 16'hFFFF+1 = 16'h0000. Operands may straddle the wrap.
- Redirect, any state except RST:
  - Next cycle state=REQ_OP, pc=redirect_pc, instr_valid=0.
  - Read data returning in the cycle after a redirect is ignored.
  - A request granted in the same cycle as redirect is abandoned; its data is discarded.
- Redirect together with instr_valid & instr_ready: the handshake completes (instruction consumed) and redirect sets pc. There is no sequential pc increment.
- Reset asserted mid-fetch: immediate return to the reset values. Any partial instruction is lost.
- mem_rd never drops while waiting for a grant, except on redirect or reset.

Test Plan:
- Reset with RESET_PC=16'h0200, mem[0200]=EA (NOP, size 1), grant always 1, instr_ready=1 → mem_rd=0 in first post-reset cycle; instr_valid at cycle 2 with opcode EA, op1=00, op2=00, instr_pc=0200, instr_next_pc=0201.
- mem[0200..0202]=4C 34 12 (JMP abs), grant always 1 → instr_valid at cycle 6, op1=34, op2=12, next_pc=0203; reads issued at 0200, 0201, 0202 in order.
- mem[0200..0201]=A9 55, instr_ready held 0 for 5 cycles → outputs stable and no new mem_rd during the stall; the next opcode request is at 0202 one cycle after ready.
- mem_gnt low for 3 cycles on the operand request of A9 55 → mem_rd and mem_addr=0201 held; instr_valid delayed by exactly 3 cycles.
- redirect=1 with redirect_pc=0300 during WAIT_B1 of a 2-byte instruction → the stale byte is discarded, instr_valid never asserted for it, next request at 0300.
- RESET_PC=FFFF, mem[FFFF]=A9, mem[0000]=77 → instr_pc=FFFF, op1=77, instr_next_pc=0001.
